// File: rtl/fm_buffer_loader.sv
// Write side of the FM ping-pong buffers: scatters genome bytes into buffer coordinates.
// Optional FM_LOADER_PAD_EN zero-fills a buffer sealed early by in_last.
module fm_buffer_loader #(
    parameter int GENOME_BYTE      = 8,
    parameter int FM_BUFFER_COUNT  = 2,
    parameter int FM_RAMS_COUNT    = 2,
    parameter int FM_ENTRIES_COUNT = 2,
    parameter int FM_OFFSET_COUNT  = 2,
    localparam int CAP   = FM_RAMS_COUNT * FM_ENTRIES_COUNT * FM_OFFSET_COUNT,
    localparam int LEN_W = $clog2(CAP + 1),
    localparam int CNT_W = (CAP > 1) ? $clog2(CAP) : 1,
    localparam int BUF_W = (FM_BUFFER_COUNT > 1) ? $clog2(FM_BUFFER_COUNT) : 1,
    localparam int RAM_W = (FM_RAMS_COUNT > 1) ? $clog2(FM_RAMS_COUNT) : 1,
    localparam int ENT_W = (FM_ENTRIES_COUNT > 1) ? $clog2(FM_ENTRIES_COUNT) : 1,
    localparam int OFF_W = (FM_OFFSET_COUNT > 1) ? $clog2(FM_OFFSET_COUNT) : 1
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             in_valid,
    input  logic [GENOME_BYTE-1:0]           in_data,
    input  logic                             in_last,
    output logic                             in_ready,
    output logic                             wr_en,
    output logic [BUF_W-1:0]                 wr_buf,
    output logic [RAM_W-1:0]                 wr_ram,
    output logic [ENT_W-1:0]                 wr_entry,
    output logic [OFF_W-1:0]                 wr_offset,
    output logic [GENOME_BYTE-1:0]           wr_data,
    output logic [FM_BUFFER_COUNT-1:0]       buf_full_o,
    output logic [FM_BUFFER_COUNT-1:0]       buf_last_o,
    output logic [FM_BUFFER_COUNT*LEN_W-1:0] buf_bytes_o,
    input  logic [FM_BUFFER_COUNT-1:0]       buf_release_i,
    output logic                             busy_o
);

    typedef enum logic [1:0] {
        FILL = 2'd0,
        SEAL = 2'd1
`ifdef FM_LOADER_PAD_EN
        , PAD = 2'd2
`endif
    } state_t;

    state_t                     state, state_nxt;
    logic [BUF_W-1:0]           cur_buf, cur_nxt;
    logic [CNT_W-1:0]           n, n_nxt;
    logic [LEN_W-1:0]           seal_cnt;
    logic                       seal_last;
    logic [FM_BUFFER_COUNT-1:0] rel, full_nxt;
    logic                       hs, at_end, trig, ready_nxt, busy_nxt;
    logic [RAM_W-1:0]           a_ram;
    logic [ENT_W-1:0]           a_ent;
    logic [OFF_W-1:0]           a_off;
    int                         n_i;

    always_comb begin
        n_i       = int'(n);
        a_off     = OFF_W'(n_i % FM_OFFSET_COUNT);
        a_ent     = ENT_W'((n_i / FM_OFFSET_COUNT) % FM_ENTRIES_COUNT);
        a_ram     = RAM_W'(n_i / (FM_OFFSET_COUNT * FM_ENTRIES_COUNT));
        hs        = in_valid && in_ready;
        at_end    = (n_i == CAP - 1);
        trig      = hs && (in_last || at_end);
        rel       = buf_release_i & buf_full_o;
        full_nxt  = buf_full_o & ~rel;
        cur_nxt   = cur_buf;
        n_nxt     = n;
        state_nxt = state;
        unique case (state)
            FILL: begin
                if (hs && !trig) begin
                    n_nxt = CNT_W'(n_i + 1);
                end
                if (trig) begin
                    state_nxt = SEAL;
`ifdef FM_LOADER_PAD_EN
                    if (!at_end) begin
                        state_nxt = PAD;
                        n_nxt     = CNT_W'(n_i + 1);
                    end
`endif
                end
            end
`ifdef FM_LOADER_PAD_EN
            PAD: begin
                if (at_end) state_nxt = SEAL;
                else        n_nxt     = CNT_W'(n_i + 1);
            end
`endif
            SEAL: begin
                full_nxt[cur_buf] = 1'b1;
                cur_nxt   = (cur_buf == BUF_W'(FM_BUFFER_COUNT - 1))
                          ? '0 : BUF_W'(int'(cur_buf) + 1);
                n_nxt     = '0;
                state_nxt = FILL;
            end
            default: state_nxt = FILL;
        endcase
        // in_ready is registered, so it is predicted from next-cycle state
        ready_nxt = (state_nxt == FILL) && !full_nxt[cur_nxt];
        busy_nxt  = (|full_nxt) || (n_nxt != '0) || (state_nxt != FILL);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= FILL;
            cur_buf     <= '0;
            n           <= '0;
            seal_cnt    <= '0;
            seal_last   <= 1'b0;
            in_ready    <= 1'b0;
            busy_o      <= 1'b0;
            wr_en       <= 1'b0;
            wr_buf      <= '0;
            wr_ram      <= '0;
            wr_entry    <= '0;
            wr_offset   <= '0;
            wr_data     <= '0;
            buf_full_o  <= '0;
            buf_last_o  <= '0;
            buf_bytes_o <= '0;
        end else begin
            state      <= state_nxt;
            cur_buf    <= cur_nxt;
            n          <= n_nxt;
            in_ready   <= ready_nxt;
            busy_o     <= busy_nxt;
            buf_full_o <= full_nxt;
            wr_en      <= 1'b0;
            if (hs) begin
                wr_en     <= 1'b1;
                wr_buf    <= cur_buf;
                wr_ram    <= a_ram;
                wr_entry  <= a_ent;
                wr_offset <= a_off;
                wr_data   <= in_data;
            end
`ifdef FM_LOADER_PAD_EN
            if (state == PAD) begin
                wr_en     <= 1'b1;
                wr_buf    <= cur_buf;
                wr_ram    <= a_ram;
                wr_entry  <= a_ent;
                wr_offset <= a_off;
                wr_data   <= '0;
            end
`endif
            if (trig) begin
                seal_cnt  <= LEN_W'(n_i + 1);
                seal_last <= in_last;
            end
            for (int k = 0; k < FM_BUFFER_COUNT; k++) begin
                if (rel[k]) begin
                    buf_last_o[k]                  <= 1'b0;
                    buf_bytes_o[k*LEN_W +: LEN_W]  <= '0;
                end
            end
            if (state == SEAL) begin
                buf_last_o[cur_buf]                          <= seal_last;
                buf_bytes_o[int'(cur_buf)*LEN_W +: LEN_W]    <= seal_cnt;
            end
        end
    end

endmodule

// File: tb/tb_fm_buffer_loader.sv
// Self-checking bench for fm_buffer_loader; reference model works on linear byte counts.
// Build with +define+FM_LOADER_PAD_EN to exercise zero-fill of partial buffers.
module tb_fm_buffer_loader;

    localparam int CAP = 8;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic [7:0] in_data = 8'h00;
    logic       in_last = 1'b0;
    logic       in_ready;
    logic       wr_en;
    logic [0:0] wr_buf, wr_ram, wr_entry, wr_offset;
    logic [7:0] wr_data;
    logic [1:0] buf_full_o, buf_last_o;
    logic [7:0] buf_bytes_o;
    logic [1:0] buf_release_i = 2'b00;
    logic       busy_o;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int obs_w[$];
    int obs_t[$];
    int obs_s[$];
    int exp_w[$];
    int exp_s[$];
    logic [1:0] prev_full = 2'b00;
    bit done;

    fm_buffer_loader dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_data(in_data), .in_last(in_last), .in_ready(in_ready),
        .wr_en(wr_en), .wr_buf(wr_buf), .wr_ram(wr_ram), .wr_entry(wr_entry),
        .wr_offset(wr_offset), .wr_data(wr_data),
        .buf_full_o(buf_full_o), .buf_last_o(buf_last_o), .buf_bytes_o(buf_bytes_o),
        .buf_release_i(buf_release_i), .busy_o(busy_o)
    );

    always #5 clk = ~clk;

    // hex digits: buf ram entry offset data(2)
    function automatic int coord(int b, int n, int d);
        return (b << 20) | ((n / 4) << 16) | (((n / 2) % 2) << 12) | ((n % 2) << 8) | d;
    endfunction

    function automatic int cur_wr();
        return (int'(wr_buf) << 20) | (int'(wr_ram) << 16) | (int'(wr_entry) << 12)
             | (int'(wr_offset) << 8) | int'(wr_data);
    endfunction

    always @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_full = 2'b00;
        end else begin
            cyc++;
            if (wr_en) begin
                obs_w.push_back(cur_wr());
                obs_t.push_back(cyc);
            end
            for (int k = 0; k < 2; k++)
                if (buf_full_o[k] && !prev_full[k])
                    obs_s.push_back((k << 8) | (int'(buf_last_o[k]) << 7)
                                    | int'(buf_bytes_o[k*4 +: 4]));
            prev_full = buf_full_o;
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic do_reset();
        in_valid = 1'b0;
        in_last = 1'b0;
        buf_release_i = 2'b00;
        rst_n = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
        obs_w.delete(); obs_t.delete(); obs_s.delete();
        exp_w.delete(); exp_s.delete();
    endtask

    task automatic send(input logic [7:0] d, input logic l);
        int w;
        w = 0;
        in_valid = 1'b1;
        in_data = d;
        in_last = l;
        while (!in_ready && w < 300) begin
            tick();
            w++;
        end
        checks++;
        if (!in_ready) begin
            errors++;
            $display("FAIL send_timeout byte %h waited %0d cycles, want in_ready=1", d, w);
        end else begin
            tick();
        end
        in_valid = 1'b0;
        in_last = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) tick();
        checks++;
        if ({wr_en, in_ready, busy_o, buf_full_o, buf_last_o, buf_bytes_o, cur_wr()} !== '0) begin
            errors++;
            $display("FAIL reset_outputs got wr_en=%b rdy=%b busy=%b full=%b last=%b bytes=%h wr=%h, want 0",
                     wr_en, in_ready, busy_o, buf_full_o, buf_last_o, buf_bytes_o, cur_wr());
        end
        rst_n = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL ready_before_edge got %b want 0", in_ready);
        end
        tick();
        checks++;
        if (in_ready !== 1'b1 || busy_o !== 1'b0) begin
            errors++;
            $display("FAIL ready_after_reset got rdy=%b busy=%b want 1/0", in_ready, busy_o);
        end
        for (int i = 0; i < 9; i++) send(8'($urandom), 1'b0);
        checks++;
        if (wr_en !== 1'b1 || buf_full_o !== 2'b01 || busy_o !== 1'b1) begin
            errors++;
            $display("FAIL midfill_pre got wr_en=%b full=%b busy=%b want 1/01/1", wr_en, buf_full_o, busy_o);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (wr_en !== 1'b0 || busy_o !== 1'b0 || buf_full_o !== 2'b00 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL async_reset got wr_en=%b busy=%b full=%b rdy=%b want 0",
                     wr_en, busy_o, buf_full_o, in_ready);
        end
    endtask

    task automatic test_full_stream();
        do_reset();
        for (int i = 0; i < 8; i++) send(8'(8'h10 + i), i == 7);
        checks++;
        if (wr_en !== 1'b1 || wr_data !== 8'h17 || in_ready !== 1'b0 || buf_full_o !== 2'b00) begin
            errors++;
            $display("FAIL final_write got wr_en=%b data=%h rdy=%b full=%b want 1/17/0/00",
                     wr_en, wr_data, in_ready, buf_full_o);
        end
        tick();
        checks++;
        if (buf_full_o !== 2'b01 || buf_bytes_o[3:0] !== 4'd8 || buf_last_o !== 2'b01) begin
            errors++;
            $display("FAIL seal_full got full=%b bytes0=%0d last=%b want 01/8/01",
                     buf_full_o, buf_bytes_o[3:0], buf_last_o);
        end
        checks++;
        if (obs_w.size() != 8) begin
            errors++;
            $display("FAIL stream_count got %0d writes want 8", obs_w.size());
        end else begin
            for (int i = 0; i < 8; i++) begin
                checks++;
                if (obs_w[i] != coord(0, i, 8'h10 + i)) begin
                    errors++;
                    $display("FAIL stream_wr[%0d] got %h want %h", i, obs_w[i], coord(0, i, 8'h10 + i));
                end
            end
            checks++;
            if (obs_w[2] != 'h001012 || obs_w[4] != 'h010014 || obs_w[7] != 'h011117) begin
                errors++;
                $display("FAIL stream_coords got %h %h %h want 001012 010014 011117",
                         obs_w[2], obs_w[4], obs_w[7]);
            end
            checks++;
            if (obs_t[7] - obs_t[0] != 7) begin
                errors++;
                $display("FAIL back_to_back got span %0d want 7", obs_t[7] - obs_t[0]);
            end
        end
        checks++;
        if (obs_s.size() != 1 || obs_s[0] != 'h88) begin
            errors++;
            $display("FAIL stream_seal got n=%0d first=%h want 1/88", obs_s.size(),
                     obs_s.size() > 0 ? obs_s[0] : -1);
        end
    endtask

    task automatic test_stall();
        logic [7:0] d;
        do_reset();
        for (int i = 0; i < 16; i++) begin
            d = 8'($urandom);
            send(d, 1'b0);
            exp_w.push_back(coord(i / 8, i % 8, d));
        end
        tick();
        in_valid = 1'b1;
        in_data = 8'hAA;
        checks++;
        if (buf_full_o !== 2'b11) begin
            errors++;
            $display("FAIL stall_full got %b want 11", buf_full_o);
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (in_ready !== 1'b0 || wr_en !== 1'b0) begin
                errors++;
                $display("FAIL stall_hold[%0d] got rdy=%b wr_en=%b want 0/0", i, in_ready, wr_en);
            end
            tick();
        end
        buf_release_i = 2'b01;
        tick();
        buf_release_i = 2'b00;
        checks++;
        if (buf_full_o !== 2'b10 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL stall_release got full=%b rdy=%b want 10/1", buf_full_o, in_ready);
        end
        tick();
        in_valid = 1'b0;
        checks++;
        if (wr_en !== 1'b1 || cur_wr() != 'h0000AA) begin
            errors++;
            $display("FAIL held_byte got wr_en=%b wr=%h want 1/0000aa", wr_en, cur_wr());
        end
        checks++;
        if (obs_w.size() != 17) begin
            errors++;
            $display("FAIL stall_count got %0d writes want 17", obs_w.size());
        end else begin
            for (int i = 0; i < 16; i++) begin
                checks++;
                if (obs_w[i] != exp_w[i]) begin
                    errors++;
                    $display("FAIL stall_wr[%0d] got %h want %h", i, obs_w[i], exp_w[i]);
                end
            end
        end
        checks++;
        if (obs_s.size() != 2 || obs_s[0] != 'h008 || obs_s[1] != 'h108) begin
            errors++;
            $display("FAIL stall_seals got n=%0d", obs_s.size());
        end
    endtask

    task automatic test_short_last();
        logic [7:0] d;
        do_reset();
        for (int i = 0; i < 3; i++) send(8'($urandom), i == 2);
`ifdef FM_LOADER_PAD_EN
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if (wr_en !== 1'b1 || cur_wr() != coord(0, 3 + i, 0) || buf_full_o !== 2'b00) begin
                errors++;
                $display("FAIL pad_wr[%0d] got wr_en=%b wr=%h full=%b want 1/%h/00",
                         i, wr_en, cur_wr(), buf_full_o, coord(0, 3 + i, 0));
            end
        end
`endif
        tick();
        checks++;
        if (buf_full_o !== 2'b01 || buf_bytes_o[3:0] !== 4'd3 || buf_last_o !== 2'b01) begin
            errors++;
            $display("FAIL short_seal got full=%b bytes0=%0d last=%b want 01/3/01",
                     buf_full_o, buf_bytes_o[3:0], buf_last_o);
        end
        d = 8'($urandom);
        send(d, 1'b0);
        checks++;
        if (wr_en !== 1'b1 || cur_wr() != coord(1, 0, d)) begin
            errors++;
            $display("FAIL next_buf_wr got wr_en=%b wr=%h want 1/%h", wr_en, cur_wr(), coord(1, 0, d));
        end
    endtask

    task automatic test_release_cases();
        do_reset();
        buf_release_i = 2'b10;
        tick();
        buf_release_i = 2'b00;
        checks++;
        if (buf_full_o !== 2'b00 || buf_bytes_o !== 8'h00 || busy_o !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL empty_release got full=%b bytes=%h busy=%b rdy=%b want 00/00/0/1",
                     buf_full_o, buf_bytes_o, busy_o, in_ready);
        end
        for (int i = 0; i < 8; i++) send(8'($urandom), 1'b0);
        tick();
        checks++;
        if (buf_full_o !== 2'b01) begin
            errors++;
            $display("FAIL first_seal got full=%b want 01", buf_full_o);
        end
        for (int i = 0; i < 8; i++) send(8'($urandom), 1'b0);
        buf_release_i = 2'b01;
        tick();
        buf_release_i = 2'b00;
        checks++;
        if (buf_full_o !== 2'b10 || buf_bytes_o !== 8'h80 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL seal_and_release got full=%b bytes=%h rdy=%b want 10/80/1",
                     buf_full_o, buf_bytes_o, in_ready);
        end
    endtask

    task automatic test_random();
        int budget;
        do_reset();
        done = 1'b0;
        budget = 0;
        fork
            begin
                int mbuf, mcnt, len;
                logic [7:0] d;
                logic l;
                mbuf = 0;
                mcnt = 0;
                for (int p = 0; p < 10; p++) begin
                    len = $urandom_range(1, 20);
                    for (int j = 0; j < len; j++) begin
                        d = 8'($urandom);
                        l = (j == len - 1);
                        if ($urandom % 4 == 0) repeat ($urandom_range(1, 3)) tick();
                        exp_w.push_back(coord(mbuf, mcnt, d));
                        mcnt++;
                        if (l || mcnt == CAP) begin
`ifdef FM_LOADER_PAD_EN
                            if (l)
                                for (int z = mcnt; z < CAP; z++) exp_w.push_back(coord(mbuf, z, 0));
`endif
                            exp_s.push_back((mbuf << 8) | (int'(l) << 7) | mcnt);
                            mbuf = (mbuf + 1) % 2;
                            mcnt = 0;
                        end
                        send(d, l);
                    end
                end
                done = 1'b1;
            end
            begin
                while (!(done && obs_s.size() == exp_s.size() && buf_full_o == 2'b00)
                       && budget < 20000) begin
                    buf_release_i = ($urandom % 3 == 0) ? 2'($urandom) : 2'b00;
                    tick();
                    budget++;
                end
                buf_release_i = 2'b00;
            end
        join
        tick();
        checks++;
        if (budget >= 20000) begin
            errors++;
            $display("FAIL random_drain got budget %0d exhausted, want drained", budget);
        end
        checks++;
        if (obs_w.size() != exp_w.size()) begin
            errors++;
            $display("FAIL random_wr_count got %0d want %0d", obs_w.size(), exp_w.size());
        end else begin
            for (int i = 0; i < exp_w.size(); i++) begin
                checks++;
                if (obs_w[i] != exp_w[i]) begin
                    errors++;
                    $display("FAIL random_wr[%0d] got %h want %h", i, obs_w[i], exp_w[i]);
                end
            end
        end
        checks++;
        if (obs_s.size() != exp_s.size()) begin
            errors++;
            $display("FAIL random_seal_count got %0d want %0d", obs_s.size(), exp_s.size());
        end else begin
            for (int i = 0; i < exp_s.size(); i++) begin
                checks++;
                if (obs_s[i] != exp_s[i]) begin
                    errors++;
                    $display("FAIL random_seal[%0d] got %h want %h", i, obs_s[i], exp_s[i]);
                end
            end
        end
        checks++;
        if (busy_o !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL random_idle got busy=%b rdy=%b want 0/1", busy_o, in_ready);
        end
    endtask

    initial begin
        test_reset();
        test_full_stream();
        test_stall();
        test_short_last();
        test_release_cases();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

endmodule
